hdmi_line_fetch_ctrl: RTL

Generalised successor to the single-address fill-FIFO controller in the hdmi_out read path. It splits each video line into bounded DDR read bursts and issues them with a req/ack handshake whenever the pixel FIFO requests data. It selects between two frame buffers at each vsync, tracks the line count, and flags line underruns. It sits between the hdmi_out slave registers/timing generator and the DDR read master.

---
 rtl/hdmi_line_fetch_ctrl_if.sv | 13 +
 rtl/hdmi_line_fetch_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/hdmi_line_fetch_ctrl_if.sv
// DDR burst request bundle between the line fetch controller (master) and the DDR read master (slave).
interface hdmi_line_fetch_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 12
);
    logic [ADDR_W-1:0] ddr_addr_to_read;
    logic [CNT_W+2:0]  burst_bytes;
    logic              go_fill_fifo;
    logic              burst_ack;

    modport master (output ddr_addr_to_read, output burst_bytes, output go_fill_fifo, input burst_ack);
    modport slave  (input ddr_addr_to_read, input burst_bytes, input go_fill_fifo, output burst_ack);
endinterface

// File: rtl/hdmi_line_fetch_ctrl.sv
// Splits video lines into bounded DDR read bursts, double-buffered at vsync; HDMI_LINE_DOUBLE_EN enables scan doubling.
// Latency: sync events act one cycle after the edge; a request rises the cycle after the fetch decision.
// Backpressure: a raised request holds address/length until burst_ack; syncs arriving meanwhile are queued.
module hdmi_line_fetch_ctrl #(
    parameter int ADDR_W          = 32,
    parameter int CNT_W           = 12,
    parameter int MAX_BURST_BYTES = 128
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   hsync_I,
    input  logic                   vsync_I,
    input  logic                   fill_half_fifo_I,
    input  logic [ADDR_W-1:0]      frame_base0,
    input  logic [ADDR_W-1:0]      frame_base1,
    input  logic                   buf_sel,
    input  logic [ADDR_W-1:0]      line_stride,
    input  logic [CNT_W-1:0]       pixels_per_line,
    input  logic [2:0]             bytes_per_pixel,
    input  logic [CNT_W-1:0]       lines_per_frame,
    hdmi_line_fetch_ctrl_if.master ddr,
    output logic [CNT_W-1:0]       line_count,
    output logic                   frame_done,
    output logic                   underrun
);
    localparam int LB_W = CNT_W + 3;

    typedef enum logic [1:0] {DISABLED, WAIT_VSYNC, FETCH, REQ} state_t;
    state_t state, state_nxt;

    logic              hsync_prev, vsync_prev, pend_h, pend_v;
    logic              hs_evt, vs_evt, ev_h, ev_v;
    logic [ADDR_W-1:0] line_addr, rd_addr, base, next_line_addr;
    logic [LB_W-1:0]   remaining, line_bytes, burst_len;
    logic              last_line, ack_last;
    logic              do_frame, do_line, do_issue, do_ack;

    assign hs_evt     = hsync_I & ~hsync_prev;
    assign vs_evt     = vsync_I & ~vsync_prev;
    assign ev_h       = hs_evt | pend_h;
    assign ev_v       = vs_evt | pend_v;
    assign base       = buf_sel ? frame_base1 : frame_base0;
    assign line_bytes = LB_W'(pixels_per_line) * LB_W'(bytes_per_pixel);
    assign burst_len  = (remaining > LB_W'(MAX_BURST_BYTES)) ? LB_W'(MAX_BURST_BYTES) : remaining;
    assign last_line  = (line_count == lines_per_frame - CNT_W'(1));
    assign ack_last   = (remaining == ddr.burst_bytes) && last_line;

`ifdef HDMI_LINE_DOUBLE_EN
    // Moving to an odd line count repeats the current source line.
    assign next_line_addr = line_count[0] ? line_addr + line_stride : line_addr;
`else
    assign next_line_addr = line_addr + line_stride;
`endif

    always_comb begin
        state_nxt = state;
        do_frame  = 1'b0;
        do_line   = 1'b0;
        do_issue  = 1'b0;
        do_ack    = 1'b0;
        case (state)
            DISABLED: begin
                if (start) state_nxt = WAIT_VSYNC;
            end
            WAIT_VSYNC: begin
                if (!start) begin
                    state_nxt = DISABLED;
                end else if (ev_v) begin
                    do_frame  = 1'b1;
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                if (!start) begin
                    state_nxt = DISABLED;
                end else if (ev_v) begin
                    do_frame = 1'b1;
                end else if (ev_h) begin
                    do_line = 1'b1;
                end else if (fill_half_fifo_I && remaining != '0) begin
                    do_issue  = 1'b1;
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ddr.burst_ack) begin
                    do_ack = 1'b1;
                    if (!start)        state_nxt = DISABLED;
                    else if (ack_last) state_nxt = WAIT_VSYNC;
                    else               state_nxt = FETCH;
                end
            end
            default: state_nxt = DISABLED;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state                <= DISABLED;
            hsync_prev           <= 1'b0;
            vsync_prev           <= 1'b0;
            pend_h               <= 1'b0;
            pend_v               <= 1'b0;
            line_addr            <= '0;
            rd_addr              <= '0;
            remaining            <= '0;
            line_count           <= '0;
            frame_done           <= 1'b0;
            underrun             <= 1'b0;
            ddr.ddr_addr_to_read <= '0;
            ddr.burst_bytes      <= '0;
            ddr.go_fill_fifo     <= 1'b0;
        end else begin
            state      <= state_nxt;
            hsync_prev <= hsync_I;
            vsync_prev <= vsync_I;
            frame_done <= 1'b0;
            if (do_frame) begin
                line_addr  <= base;
                rd_addr    <= base;
                remaining  <= line_bytes;
                line_count <= '0;
                pend_h     <= 1'b0;
                pend_v     <= 1'b0;
            end
            if (do_line) begin
                pend_h <= 1'b0;
                // A line start on the final line is swallowed.
                if (!last_line) begin
                    if (remaining != '0) underrun <= 1'b1;
                    line_addr  <= next_line_addr;
                    rd_addr    <= next_line_addr;
                    remaining  <= line_bytes;
                    line_count <= line_count + CNT_W'(1);
                end
            end
            if (do_issue) begin
                ddr.ddr_addr_to_read <= rd_addr;
                ddr.burst_bytes      <= burst_len;
                ddr.go_fill_fifo     <= 1'b1;
            end
            if (do_ack) begin
                rd_addr          <= rd_addr + ADDR_W'(ddr.burst_bytes);
                remaining        <= remaining - ddr.burst_bytes;
                ddr.go_fill_fifo <= 1'b0;
                if (ack_last) frame_done <= 1'b1;
            end
            if (state == REQ) begin
                pend_h <= pend_h | hs_evt;
                pend_v <= pend_v | vs_evt;
            end
            if (state_nxt == DISABLED) begin
                pend_h           <= 1'b0;
                pend_v           <= 1'b0;
                ddr.go_fill_fifo <= 1'b0;
            end
        end
    end
endmodule
